mem_wait_responder: RTL and testbench

- Memory-side responder for the microprogrammed controller's `wait_` handshake.
- Consumes the memory read/write strobes decoded from the controller's control word, plus address and write data.
- Performs the access into a local register-file memory after a programmable latency.
- Holds `wait_` high until the access is complete, so the controller's microsequencer stalls on its `wait_` branch.

---
 rtl/mem_wait_responder.sv | 109 ++++++++++
 tb/tb_mem_wait_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wait_responder.sv
// Memory-side responder for the controller wait_ handshake.
// Each access runs for a programmable number of cycles and then commits to a local register-file memory.
module mem_wait_responder #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              wait_,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              op_wr;
    logic              req;
    logic              accept;
    logic              commit;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign req  = mem_rd | mem_wr;
    assign done = (state == DONE);

    always_comb begin
        state_nxt = state;
        wait_     = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;
        unique case (state)
            IDLE: begin
                wait_ = req;
                if (req) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                wait_ = 1'b1;
                if (!req) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    commit    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_wr   <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                op_wr   <= mem_wr;
                cnt     <= CNT_W'(LATENCY - 1);
                if (mem_rd && mem_wr) begin
                    err <= 1'b1;
                end
            end else if (state == BUSY && req && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (commit && !op_wr) begin
                rdata <= mem[addr_q];
            end
        end
    end

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (commit && op_wr) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_wait_responder.sv
// Scoreboard bench for mem_wait_responder.
// A LATENCY=3 instance covers the main scenarios and a LATENCY=1 instance covers the short-latency case.
module tb_mem_wait_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_rd, mem_wr;
    logic [7:0]  addr;
    logic [15:0] wdata, rdata;
    logic        wait_, done, err;

    logic        rd1, wr1;
    logic [7:0]  addr1;
    logic [15:0] wdata1, rdata1;
    logic        wait1, done1, err1;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] model_mem [256];
    logic [15:0] model_rdata;
    logic        model_err;
    logic [15:0] sb [$];

    always #5 clk = ~clk;

    mem_wait_responder #(.DATA_W(16), .ADDR_W(8), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .addr(addr), .wdata(wdata), .rdata(rdata), .wait_(wait_),
        .done(done), .err(err)
    );

    mem_wait_responder #(.DATA_W(16), .ADDR_W(8), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .mem_rd(rd1), .mem_wr(wr1),
        .addr(addr1), .wdata(wdata1), .rdata(rdata1), .wait_(wait1),
        .done(done1), .err(err1)
    );

    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [7:0] a, input logic [15:0] d);
        logic [15:0] exp;
        @(posedge clk); #1;
        mem_rd = rd; mem_wr = wr; addr = a; wdata = d;
        if (rd && wr) model_err = 1'b1;
        if (wr) model_mem[a] = d;
        else model_rdata = model_mem[a];
        sb.push_back(model_rdata);
        for (int c = 0; c <= LAT; c++) begin
            @(negedge clk);
            vectors++;
            if ({wait_, done} !== 2'b10) begin
                miscompares++;
                $display("FAIL %s wait/done cyc%0d got %b exp 10", tag, c, {wait_, done});
            end
            if (c >= 1) begin
                vectors++;
                if (err !== model_err) begin
                    miscompares++;
                    $display("FAIL %s err cyc%0d got %b exp %b", tag, c, err, model_err);
                end
            end
            @(posedge clk); #1;
            if (c == 0) begin
                addr = ~a; wdata = ~d;
            end
        end
        @(negedge clk);
        vectors++;
        if ({wait_, done} !== 2'b01) begin
            miscompares++;
            $display("FAIL %s done cycle wait/done got %b exp 01", tag, {wait_, done});
        end
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s scoreboard empty got none exp entry", tag);
        end else begin
            exp = sb.pop_front();
            vectors++;
            if (rdata !== exp) begin
                miscompares++;
                $display("FAIL %s rdata got %h exp %h", tag, rdata, exp);
            end
        end
        mem_rd = 1'b0; mem_wr = 1'b0;
    endtask

    task automatic abort(input string tag, input logic rd, input logic wr,
                         input logic [7:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        mem_rd = rd; mem_wr = wr; addr = a; wdata = d;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                mem_rd = 1'b0; mem_wr = 1'b0;
            end
            @(negedge clk);
            vectors++;
            if ({wait_, done} !== ((c < 3) ? 2'b10 : 2'b00)) begin
                miscompares++;
                $display("FAIL %s wait/done cyc%0d got %b exp %b", tag, c,
                         {wait_, done}, (c < 3) ? 2'b10 : 2'b00);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (rdata !== model_rdata) begin
            miscompares++;
            $display("FAIL %s rdata got %h exp %h", tag, rdata, model_rdata);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_rd = 0; mem_wr = 0; addr = 0; wdata = 0;
        rd1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
        model_rdata = 16'h0; model_err = 1'b0;
        #12;
        vectors++;
        if ({wait_, done, err, rdata} !== 19'h0) begin
            miscompares++;
            $display("FAIL reset got w%b d%b e%b r%h exp all 0", wait_, done, err, rdata);
        end
        vectors++;
        if ({wait1, done1, err1, rdata1} !== 19'h0) begin
            miscompares++;
            $display("FAIL reset1 got w%b d%b e%b r%h exp all 0", wait1, done1, err1, rdata1);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        access("write", 1'b0, 1'b1, 8'h12, 16'hBEEF);
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if ({wait_, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL write_idle wait/done got %b exp 00", {wait_, done});
        end
    endtask

    task automatic test_readback();
        access("readback", 1'b1, 1'b0, 8'h12, 16'h0);
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (rdata !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL readback_hold rdata got %h exp %h", rdata, 16'hBEEF);
        end
    endtask

    task automatic test_abort();
        access("abort_setup", 1'b0, 1'b1, 8'h30, 16'h0A0A);
        abort("abort_rd", 1'b1, 1'b0, 8'h30, 16'h0);
        abort("abort_wr", 1'b0, 1'b1, 8'h30, 16'hFFFF);
        access("abort_check", 1'b1, 1'b0, 8'h30, 16'h0);
    endtask

    task automatic test_conflict();
        access("conflict", 1'b1, 1'b1, 8'h05, 16'h1234);
        access("conflict_rd", 1'b1, 1'b0, 8'h05, 16'h0);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL conflict_sticky err got %b exp 1", err);
        end
    endtask

    task automatic test_back_to_back();
        access("b2b_wr", 1'b0, 1'b1, 8'h20, 16'h5A5A);
        access("b2b_rd", 1'b1, 1'b0, 8'h20, 16'h0);
    endtask

    task automatic test_reset_mid_busy();
        access("rst_setup", 1'b0, 1'b1, 8'h40, 16'h1357);
        access("rst_setup_rd", 1'b1, 1'b0, 8'h05, 16'h0);
        @(posedge clk); #1;
        mem_wr = 1'b1; addr = 8'h40; wdata = 16'h2468;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({wait_, done, err, rdata} !== {2'b10, 1'b0, 16'h0}) begin
            miscompares++;
            $display("FAIL rst_mid got w%b d%b e%b r%h exp w1 d0 e0 r0000",
                     wait_, done, err, rdata);
        end
        mem_wr = 1'b0;
        #1;
        vectors++;
        if (wait_ !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_idle wait_ got %b exp 0", wait_);
        end
        model_rdata = 16'h0; model_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        access("rst_check", 1'b1, 1'b0, 8'h40, 16'h0);
    endtask

    task automatic test_latency1();
        logic [15:0] exp;
        for (int op = 0; op < 2; op++) begin
            @(posedge clk); #1;
            rd1 = (op == 1); wr1 = (op == 0); addr1 = 8'h33; wdata1 = 16'hC0DE;
            sb.push_back((op == 1) ? 16'hC0DE : 16'h0000);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                vectors++;
                if ({wait1, done1} !== ((c < 2) ? 2'b10 : 2'b01)) begin
                    miscompares++;
                    $display("FAIL lat1 op%0d cyc%0d wait/done got %b exp %b", op, c,
                             {wait1, done1}, (c < 2) ? 2'b10 : 2'b01);
                end
                if (c < 2) begin
                    @(posedge clk); #1;
                end
            end
            exp = sb.pop_front();
            vectors++;
            if (rdata1 !== exp) begin
                miscompares++;
                $display("FAIL lat1 op%0d rdata got %h exp %h", op, rdata1, exp);
            end
            rd1 = 1'b0; wr1 = 1'b0;
        end
        vectors++;
        if (err1 !== 1'b0) begin
            miscompares++;
            $display("FAIL lat1 err got %b exp 0", err1);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_readback();
        test_abort();
        test_conflict();
        test_back_to_back();
        test_reset_mid_busy();
        test_latency1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
